// File: rtl/line_pixel_writer.sv
// Pixel FIFO, screen clip and framebuffer write sequencer for the line rasteriser.
// Optional LINE_PIXEL_DEDUP_EN drops a pixel identical to the last one queued.
module line_pixel_writer #(
    parameter int DEPTH    = 4,
    parameter int COLOUR_W = 3
) (
    input  logic                Clk,
    input  logic                RESET,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [7:0]          pix_x,
    input  logic [6:0]          pix_y,
    input  logic [COLOUR_W-1:0] pix_colour,
    output logic [14:0]         mem_addr,
    output logic [COLOUR_W-1:0] mem_data,
    output logic                mem_we,
    input  logic                mem_ack,
    output logic                busy,
    output logic [7:0]          clip_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;
    state_t state, state_nxt;

    logic [7:0]          fifo_x [DEPTH];
    logic [6:0]          fifo_y [DEPTH];
    logic [COLOUR_W-1:0] fifo_c [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;

    logic [7:0]          hold_x;
    logic [6:0]          hold_y;
    logic [COLOUR_W-1:0] hold_c;

    logic take, clipped, dup, push, pop;

    assign pix_ready = (count != CW'(DEPTH));
    assign take      = pix_valid & pix_ready;
    assign clipped   = (pix_x >= 8'd160) | (pix_y >= 7'd120);
    assign push      = take & ~clipped & ~dup;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (count != '0) | (state != IDLE);

`ifdef LINE_PIXEL_DEDUP_EN
    logic                last_valid;
    logic [7:0]          last_x;
    logic [6:0]          last_y;
    logic [COLOUR_W-1:0] last_c;

    assign dup = last_valid & (pix_x == last_x) & (pix_y == last_y) & (pix_colour == last_c);

    // Only pushed pixels update the reference, so clipped ones never mask a real repeat.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            last_valid <= 1'b0;
            last_x     <= '0;
            last_y     <= '0;
            last_c     <= '0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_x     <= pix_x;
            last_y     <= pix_y;
            last_c     <= pix_colour;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_x[wr_ptr] <= pix_x;
            fifo_y[wr_ptr] <= pix_y;
            fifo_c[wr_ptr] <= pix_colour;
        end
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            clip_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (take && clipped && (clip_count != 8'hFF))
                clip_count <= clip_count + 8'd1;
        end
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = LOAD;
            LOAD:    state_nxt = WRITE;
            WRITE:   if (mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // y*160 built as y*128 + y*32; fits 15 bits for every on-screen pixel.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            hold_x   <= '0;
            hold_y   <= '0;
            hold_c   <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
        end else begin
            if (pop) begin
                hold_x <= fifo_x[rd_ptr];
                hold_y <= fifo_y[rd_ptr];
                hold_c <= fifo_c[rd_ptr];
            end
            if (state == LOAD) begin
                mem_addr <= {1'b0, hold_y, 7'b0} + {3'b0, hold_y, 5'b0} + {7'b0, hold_x};
                mem_data <= hold_c;
                mem_we   <= 1'b1;
            end else if (state == WRITE && mem_ack) begin
                mem_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_line_pixel_writer.sv
// Scoreboard bench for line_pixel_writer: expected writes queued at acceptance,
// checked when the memory side acknowledges them.
module tb_line_pixel_writer;
    logic        Clk = 0;
    logic        RESET;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [2:0]  pix_colour;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ack;
    logic        busy;
    logic [7:0]  clip_count;

    line_pixel_writer #(.DEPTH(4), .COLOUR_W(3)) dut (
        .Clk(Clk), .RESET(RESET), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
        .busy(busy), .clip_count(clip_count)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int t0      = 0;
    int we_rise_cyc = 0;
    int writes  = 0;
    bit ack_en  = 1;
    int ack_delay = 0;

    logic [17:0] exp_q[$];
    int   exp_clip = 0;
    bit   last_valid = 0;
    logic [17:0] last_pix = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    // Memory side: drives mem_ack and checks each acknowledged write against the queue.
    initial begin
        bit in_write;
        int hold;
        logic [17:0] first, e;
        in_write = 0;
        hold = 0;
        first = '0;
        mem_ack = 0;
        forever begin
            @(negedge Clk);
            if (mem_we && !RESET) begin
                if (!in_write) begin
                    in_write = 1;
                    hold = 0;
                    we_rise_cyc = cyc;
                    first = {mem_addr, mem_data};
                end else begin
                    check("hold_stable", {14'd0, mem_addr, mem_data}, {14'd0, first});
                end
                if (ack_en && hold >= ack_delay) begin
                    mem_ack = 1;
                    writes++;
                    check("sb_nonempty", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", mem_addr, e[17:3]);
                        check("wr_data", mem_data, e[2:0]);
                    end
                    in_write = 0;
                end else begin
                    mem_ack = 0;
                end
                hold++;
            end else begin
                mem_ack = 0;
                in_write = 0;
            end
        end
    end

    // Called at a negedge; returns at a negedge with pix_valid low.
    task automatic send(input int x, input int y, input int c, input int budget, output bit acc);
        int n;
        logic [17:0] key;
        n = 0;
        pix_x = 8'(x);
        pix_y = 7'(y);
        pix_colour = 3'(c);
        pix_valid = 1;
        while (!pix_ready && n < budget) begin
            @(negedge Clk);
            n++;
        end
        if (pix_ready) begin
            @(negedge Clk);
            acc = 1;
            t0 = cyc;
            key = {pix_x, pix_y, pix_colour};
            if (x >= 160 || y >= 120) begin
                if (exp_clip < 255) exp_clip++;
            end else begin
`ifdef LINE_PIXEL_DEDUP_EN
                if (!(last_valid && last_pix == key)) begin
                    exp_q.push_back({15'(y * 160 + x), 3'(c)});
                    last_valid = 1;
                    last_pix = key;
                end
`else
                exp_q.push_back({15'(y * 160 + x), 3'(c)});
                last_pix = key;
`endif
            end
        end else begin
            acc = 0;
        end
        pix_valid = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || mem_we) && n < budget) begin
            @(negedge Clk);
            n++;
        end
        if (n >= budget) check("idle_timeout", busy, 0);
    endtask

    initial begin
        bit acc;
        int w0, nacc, n;
        RESET = 1;
        pix_valid = 0;
        pix_x = 0;
        pix_y = 0;
        pix_colour = 0;
        repeat (3) @(negedge Clk);
        check("rst_ready", pix_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check("rst_clip", clip_count, 0);
        RESET = 0;
        @(negedge Clk);

        // 1: single pixel, delayed ack
        ack_en = 1;
        ack_delay = 3;
        w0 = writes;
        send(10, 5, 3, 10, acc);
        check("t1_acc", acc, 1);
        check("t1_exp_addr", exp_q[0][17:3], 810);
        n = 0;
        while (!mem_we && n < 10) begin @(negedge Clk); n++; end
        check("t1_we_up", mem_we, 1);
        check("t1_latency", we_rise_cyc - t0, 2);
        wait_idle(50);
        @(negedge Clk);
        check("t1_writes", writes - w0, 1);
        check("t1_we_low", mem_we, 0);
        check("t1_busy", busy, 0);

        // 2: clipped pixels
        ack_delay = 0;
        w0 = writes;
        send(160, 0, 1, 10, acc);
        send(0, 120, 2, 10, acc);
        check("t2_ready", pix_ready, 1);
        repeat (6) @(negedge Clk);
        check("t2_clip", clip_count, exp_clip);
        check("t2_writes", writes - w0, 0);
        check("t2_we", mem_we, 0);

        // 3: far corner
        w0 = writes;
        send(159, 119, 7, 10, acc);
        check("t3_exp_addr", exp_q[0][17:3], 19199);
        wait_idle(50);
        check("t3_writes", writes - w0, 1);

        // 4: stalled ack, capacity then drain
        ack_en = 0;
        w0 = writes;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            send(20 + i, 10 + i, i, (i < 5) ? 10 : 4, acc);
            if (acc) nacc++;
        end
        check("t4_accepted", nacc, 5);
        check("t4_last_rej", acc, 0);
        check("t4_ready", pix_ready, 0);
        check("t4_busy", busy, 1);
        ack_en = 1;
        n = 0;
        while (!pix_ready && n < 10) begin @(negedge Clk); n++; end
        check("t4_ready_back", pix_ready, 1);
        wait_idle(100);
        check("t4_writes", writes - w0, 5);

        // 5: reset in WRITE with three queued
        ack_en = 0;
        w0 = writes;
        for (int i = 0; i < 4; i++) send(40 + i, 50, 5, 10, acc);
        n = 0;
        while (!mem_we && n < 20) begin @(negedge Clk); n++; end
        check("t5_we_up", mem_we, 1);
        RESET = 1;
        #1;
        check("t5_we", mem_we, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", pix_ready, 1);
        check("t5_clip", clip_count, 0);
        exp_q.delete();
        exp_clip = 0;
        last_valid = 0;
        @(negedge Clk);
        RESET = 0;
        ack_en = 1;
        repeat (20) @(negedge Clk);
        check("t5_writes", writes - w0, 0);
        check("t5_busy_after", busy, 0);

        // 6: repeated pixel
        w0 = writes;
        for (int i = 0; i < 3; i++) send(4, 4, 1, 10, acc);
        wait_idle(100);
`ifdef LINE_PIXEL_DEDUP_EN
        check("t6_writes", writes - w0, 1);
`else
        check("t6_writes", writes - w0, 3);
`endif
        check("t6_clip", clip_count, exp_clip);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
